// File: rtl/peripheral_msi_ahb2apb4_bridge.sv
// AHB-Lite responder that turns each accepted AHB beat into one
// APB4 transfer; APB wait states stretch the AHB data phase.
module peripheral_msi_ahb2apb4_bridge #(
  parameter int PLEN       = 64,
  parameter int XLEN       = 64,
  parameter int PADDR_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [PLEN-1:0]       HADDR,
  input  logic [XLEN-1:0]       HWDATA,
  output logic [XLEN-1:0]       HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int LW = (XLEN > 32) ? $clog2(XLEN / 32) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        r_state;
  logic [LW-1:0] r_lane;
  logic [LW-1:0] w_lane;
  logic [3:0]    w_strb;
  logic          w_accept;
  logic          w_unused;

  assign w_accept = HSEL & HREADY & HTRANS[1];

  assign w_unused = ^{HBURST, HMASTLOCK, HPROT[3:2],
                      HTRANS[0], HADDR, HWDATA};

  // 32-bit lane of the wide AHB bus addressed by this beat
  always_comb begin
    w_lane = '0;
    if (XLEN > 32) w_lane = HADDR[LW+1:2];
  end

  always_comb begin
    w_strb = 4'b0000;
    if (HWRITE) begin
      unique case (HSIZE)
        3'd0:    w_strb = 4'b0001 << HADDR[1:0];
        3'd1:    w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
        default: w_strb = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (w_accept) begin
            r_lane <= w_lane;
            PADDR  <= HADDR[PADDR_SIZE-1:0];
            PWRITE <= HWRITE;
            PSTRB  <= w_strb;
            PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
            HREADYOUT <= 1'b0;
            if (HSIZE > 3'd2) begin
              r_state <= S_ERR1;
              HRESP   <= 1'b1;
            end else if (HWRITE) begin
              r_state <= S_WDATA;
              HRESP   <= 1'b0;
            end else begin
              r_state <= S_SETUP;
              HRESP   <= 1'b0;
              PSEL    <= 1'b1;
            end
          end else begin
            r_state   <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        S_WDATA: begin
          PWDATA  <= HWDATA[{r_lane, 5'b0} +: 32];
          PSEL    <= 1'b1;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              r_state <= S_ERR1;
              HRESP   <= 1'b1;
            end else begin
              r_state   <= S_DONE;
              HREADYOUT <= 1'b1;
              if (!PWRITE) HRDATA <= {(XLEN/32){PRDATA}};
            end
          end
        end
        S_ERR1: begin
          r_state   <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_msi_ahb2apb4_bridge.sv
// Bench for the AHB-to-APB4 bridge: vector table plus an APB
// target model that checks each transfer against a queue.
module tb_peripheral_msi_ahb2apb4_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  peripheral_msi_ahb2apb4_bridge #(
    .PLEN(64), .XLEN(64), .PADDR_SIZE(32)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [63:0] hwdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic        b2b;
    logic [3:0]  e_strb;
    logic [31:0] e_pwdata;
    logic [2:0]  e_pprot;
    logic [63:0] e_hrdata;
    logic        e_resp;
    int          e_waits;
    int          e_psel;
  } vec_t;

  typedef struct {
    logic [31:0] paddr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
  } apb_t;

  apb_t        apb_q[$];
  vec_t        v[12];
  int          n_chk = 0;
  int          n_fail = 0;
  int          psel_cyc = 0;
  int          cur_waits;
  logic        cur_slverr;
  logic [31:0] cur_prdata;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [63:0] addr, input logic wr,
    input logic [2:0] size, input logic [3:0] prot,
    input logic [63:0] hwdata, input int waits,
    input logic slverr, input logic [31:0] prdata,
    input logic b2b, input logic [3:0] e_strb,
    input logic [31:0] e_pwdata, input logic [2:0] e_pprot,
    input logic [63:0] e_hrdata, input logic e_resp,
    input int e_waits, input int e_psel);
    vec_t t;
    t.addr = addr;       t.wr = wr;
    t.size = size;       t.prot = prot;
    t.hwdata = hwdata;   t.waits = waits;
    t.slverr = slverr;   t.prdata = prdata;
    t.b2b = b2b;         t.e_strb = e_strb;
    t.e_pwdata = e_pwdata;
    t.e_pprot = e_pprot; t.e_hrdata = e_hrdata;
    t.e_resp = e_resp;   t.e_waits = e_waits;
    t.e_psel = e_psel;
    return t;
  endfunction

  // APB target: inserts wait states, checks each completed transfer
  initial begin : apb_target
    int          acc;
    logic [31:0] sa;
    logic        stable;
    apb_t        e;
    acc = 0; sa = '0; stable = 1'b1;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (PSEL && !PENABLE) begin
        psel_cyc++;
        acc = 0; sa = PADDR; stable = 1'b1;
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else if (PSEL && PENABLE) begin
        psel_cyc++;
        if (PADDR !== sa) stable = 1'b0;
        PREADY  = (acc >= cur_waits);
        PSLVERR = PREADY & cur_slverr;
        PRDATA  = cur_prdata;
        acc++;
        if (PREADY) begin
          if (apb_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL apb_unexpected: got transfer at 0x%0h, required none",
                     PADDR);
          end else begin
            e = apb_q.pop_front();
            chk("paddr", PADDR, e.paddr);
            chk("pwrite", PWRITE, e.wr);
            chk("pstrb", PSTRB, e.strb);
            chk("pprot", PPROT, e.pprot);
            if (e.wr) chk("pwdata", PWDATA, e.pwdata);
            chk("paddr_stable", stable, 1);
          end
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
    end
  end

  task automatic xfer(input vec_t t);
    int   w;
    logic lr;
    bit   done;
    apb_t e;
    psel_cyc   = 0;
    cur_waits  = t.waits;
    cur_slverr = t.slverr;
    cur_prdata = t.prdata;
    if (t.size <= 3'd2) begin
      e.paddr = t.addr[31:0]; e.wr = t.wr;
      e.strb = t.e_strb; e.pwdata = t.e_pwdata;
      e.pprot = t.e_pprot;
      apb_q.push_back(e);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = t.addr;
    HWRITE = t.wr; HSIZE = t.size; HPROT = t.prot;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = t.hwdata;
    w = 0; lr = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (HREADYOUT) done = 1'b1;
      else begin
        w++; lr = HRESP;
        @(negedge HCLK);
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL ahb_timeout: HREADYOUT got 0, required 1");
    end
    chk("wait_states", w, t.e_waits);
    chk("hresp", HRESP, t.e_resp);
    chk("hresp_last_wait", lr, t.e_resp);
    chk("hrdata", HRDATA, t.e_hrdata);
    chk("psel_cycles", psel_cyc, t.e_psel);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0;
    HWRITE = 1'b0; HSIZE = '0; HBURST = '0; HPROT = '0;
    HTRANS = 2'b00; HMASTLOCK = 1'b0;
    cur_waits = 0; cur_slverr = 1'b0; cur_prdata = '0;

    v[0]  = mk(64'h1004, 0, 2, 4'b0011, 64'h0, 0, 0,
               32'hCAFEBABE, 0, 4'b0000, 32'h0, 3'b001,
               64'hCAFEBABE_CAFEBABE, 0, 2, 2);
    v[1]  = mk(64'h2006, 1, 1, 4'b0010,
               64'h12345678_00000000, 0, 0, 32'h0, 0,
               4'b1100, 32'h12345678, 3'b101,
               64'hCAFEBABE_CAFEBABE, 0, 3, 2);
    v[2]  = mk(64'h3000, 0, 2, 4'b0000, 64'h0, 4, 0,
               32'h000000A5, 0, 4'b0000, 32'h0, 3'b100,
               64'h000000A5_000000A5, 0, 6, 6);
    v[3]  = mk(64'h4008, 0, 2, 4'b0001, 64'h0, 0, 1,
               32'hDEAD0000, 0, 4'b0000, 32'h0, 3'b000,
               64'h000000A5_000000A5, 1, 3, 2);
    v[4]  = mk(64'h5000, 0, 3, 4'b0011, 64'h0, 0, 0,
               32'h0, 0, 4'b0000, 32'h0, 3'b001,
               64'h000000A5_000000A5, 1, 1, 0);
    v[5]  = mk(64'h6003, 1, 0, 4'b0011,
               64'h00000000_AB000000, 0, 0, 32'h0, 0,
               4'b1000, 32'hAB000000, 3'b001,
               64'h000000A5_000000A5, 0, 3, 2);
    v[6]  = mk(64'h7001, 1, 1, 4'b0001,
               64'h11111111_22222222, 0, 0, 32'h0, 0,
               4'b0011, 32'h22222222, 3'b000,
               64'h000000A5_000000A5, 0, 3, 2);
    v[7]  = mk(64'h800F, 1, 2, 4'b0011,
               64'hAAAAAAAA_55555555, 1, 0, 32'h0, 0,
               4'b1111, 32'hAAAAAAAA, 3'b001,
               64'h000000A5_000000A5, 0, 4, 3);
    v[8]  = mk(64'h9000, 1, 2, 4'b0011,
               64'h00000000_01020304, 0, 1, 32'h0, 0,
               4'b1111, 32'h01020304, 3'b001,
               64'h000000A5_000000A5, 1, 4, 2);
    v[9]  = mk(64'hA00C, 0, 0, 4'b0011, 64'h0, 2, 0,
               32'h76543210, 0, 4'b0000, 32'h0, 3'b001,
               64'h76543210_76543210, 0, 4, 4);
    v[10] = mk(64'hB000, 0, 2, 4'b0011, 64'h0, 0, 0,
               32'h0BADF00D, 1, 4'b0000, 32'h0, 3'b001,
               64'h0BADF00D_0BADF00D, 0, 2, 2);
    v[11] = mk(64'hC004, 1, 2, 4'b0011,
               64'h00000001_FFFFFFFF, 0, 0, 32'h0, 0,
               4'b1111, 32'h00000001, 3'b001,
               64'h0BADF00D_0BADF00D, 0, 3, 2);

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_pprot", PPROT, 0);
    HRESET = 1'b0;
    @(negedge HCLK);

    psel_cyc = 0;
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 64'h100;
    @(negedge HCLK);
    chk("idle_trans_hreadyout", HREADYOUT, 1);
    chk("idle_trans_hresp", HRESP, 0);
    HSEL = 1'b0; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("unsel_hreadyout", HREADYOUT, 1);
    chk("unsel_hresp", HRESP, 0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("idle_no_psel", psel_cyc, 0);

    for (int i = 0; i < 12; i++) begin
      xfer(v[i]);
      if (!v[i].b2b) begin
        @(negedge HCLK);
        chk("idle_okay_ready", HREADYOUT, 1);
        chk("idle_okay_resp", HRESP, 0);
      end
    end

    // reset in the middle of a stalled APB access
    cur_waits = 20; cur_slverr = 1'b0; cur_prdata = 32'h1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 64'hD000;
    HWRITE = 1'b0; HSIZE = 3'd2; HPROT = 4'b0011;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (PENABLE) seen = 1'b1;
      else @(negedge HCLK);
    end
    chk("reach_access", seen, 1);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_hreadyout", HREADYOUT, 1);
    chk("rst_mid_hresp", HRESP, 0);
    chk("rst_mid_hrdata", HRDATA, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("post_rst_psel", PSEL, 0);
    chk("apb_queue_empty", apb_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
